// File: rtl/pwm_sine_sequencer.sv
// Sequences the PWM duty input through a 256-sample sine envelope, updating only on PWM period boundaries.
// Latency: duty_cycle is registered on the period_start edge and appears one cycle after the period_start cycle.
// No backpressure: start/stop are level-sampled; stop completes the current sine cycle before returning to idle.
module pwm_sine_sequencer #(
  parameter int CLK_FREQUENCY  = 33_330_000,
  parameter int FREQUENCY      = 500_000,
  parameter int SINE_FREQUENCY = 310
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [6:0]  amplitude,
  output logic [31:0] duty_cycle,
  output logic        period_start,
  output logic        busy,
  output logic [7:0]  sample_idx
);

  localparam int STEPS          = CLK_FREQUENCY / FREQUENCY;
  localparam int SAMPLE_DIV_RAW = FREQUENCY / (SINE_FREQUENCY * 256);
  localparam int SAMPLE_DIV     = (SAMPLE_DIV_RAW < 1) ? 1 : SAMPLE_DIV_RAW;
  localparam int PCW            = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int SCW            = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PCW-1:0] PC_LAST = PCW'(STEPS - 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN} state_t;

  // First quadrant of the sine, scaled to 1024: round(1024*sin(2*pi*k/256)), k = 0..64.
  function automatic logic [10:0] quarter_sine(input logic [6:0] k);
    logic [10:0] v;
    case (k)
      7'd0:  v = 11'd0;    7'd1:  v = 11'd25;   7'd2:  v = 11'd50;   7'd3:  v = 11'd75;
      7'd4:  v = 11'd100;  7'd5:  v = 11'd125;  7'd6:  v = 11'd150;  7'd7:  v = 11'd175;
      7'd8:  v = 11'd200;  7'd9:  v = 11'd224;  7'd10: v = 11'd249;  7'd11: v = 11'd273;
      7'd12: v = 11'd297;  7'd13: v = 11'd321;  7'd14: v = 11'd345;  7'd15: v = 11'd369;
      7'd16: v = 11'd392;  7'd17: v = 11'd415;  7'd18: v = 11'd438;  7'd19: v = 11'd460;
      7'd20: v = 11'd483;  7'd21: v = 11'd505;  7'd22: v = 11'd526;  7'd23: v = 11'd548;
      7'd24: v = 11'd569;  7'd25: v = 11'd590;  7'd26: v = 11'd610;  7'd27: v = 11'd630;
      7'd28: v = 11'd650;  7'd29: v = 11'd669;  7'd30: v = 11'd688;  7'd31: v = 11'd706;
      7'd32: v = 11'd724;  7'd33: v = 11'd742;  7'd34: v = 11'd759;  7'd35: v = 11'd775;
      7'd36: v = 11'd792;  7'd37: v = 11'd807;  7'd38: v = 11'd822;  7'd39: v = 11'd837;
      7'd40: v = 11'd851;  7'd41: v = 11'd865;  7'd42: v = 11'd878;  7'd43: v = 11'd891;
      7'd44: v = 11'd903;  7'd45: v = 11'd915;  7'd46: v = 11'd926;  7'd47: v = 11'd936;
      7'd48: v = 11'd946;  7'd49: v = 11'd955;  7'd50: v = 11'd964;  7'd51: v = 11'd972;
      7'd52: v = 11'd980;  7'd53: v = 11'd987;  7'd54: v = 11'd993;  7'd55: v = 11'd999;
      7'd56: v = 11'd1004; 7'd57: v = 11'd1009; 7'd58: v = 11'd1013; 7'd59: v = 11'd1016;
      7'd60: v = 11'd1019; 7'd61: v = 11'd1021; 7'd62: v = 11'd1023; 7'd63: v = 11'd1024;
      default: v = 11'd1024;  // k == 64, the peak
    endcase
    return v;
  endfunction

  // Full-cycle sine from the quarter table: quadrant picks mirror (odd quadrants) and sign (upper half).
  function automatic logic signed [11:0] sine_of(input logic [7:0] i);
    logic [6:0]  k;
    logic [11:0] mag;
    k   = i[6] ? (7'd64 - {1'b0, i[5:0]}) : {1'b0, i[5:0]};
    mag = {1'b0, quarter_sine(k)};
    return i[7] ? -$signed(mag) : $signed(mag);
  endfunction

  // Percent duty = 50 + floor(a*s/1024); clamping a to 50 keeps the result inside 0..100.
  function automatic logic [31:0] duty_of(input logic [7:0] i, input logic [6:0] amp);
    logic [6:0]         a;
    logic signed [11:0] s;
    logic signed [17:0] p;
    logic signed [17:0] q;
    a = (amp > 7'd50) ? 7'd50 : amp;
    s = sine_of(i);
    p = $signed({11'd0, a}) * $signed({{6{s[11]}}, s});
    q = p >>> 10;
    return {{14{q[17]}}, q} + 32'd50;
  endfunction

  state_t           state_q, state_d;
  logic [PCW-1:0]   period_cnt_q;
  logic [SCW-1:0]   sample_cnt_q, sample_cnt_d, sample_cnt_step;
  logic [7:0]       idx_q, idx_d, idx_step, load_idx;
  logic [31:0]      duty_q, duty_d, duty_load;
  logic             sample_last, cycle_end, resume;

  // Free-running PWM period timebase, independent of the sequencer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      period_cnt_q <= '0;
    else if (period_cnt_q == PC_LAST) period_cnt_q <= '0;
    else                             period_cnt_q <= period_cnt_q + PCW'(1);
  end

  assign period_start    = (period_cnt_q == '0);
  assign sample_last     = (sample_cnt_q == SC_LAST);
  assign idx_step        = sample_last ? idx_q + 8'd1 : idx_q;
  assign sample_cnt_step = sample_last ? '0 : sample_cnt_q + SCW'(1);
  assign cycle_end       = sample_last && (idx_q == 8'hFF);
  assign resume          = start && !stop;
  // One shared duty calculator: ARM always loads sample 0, RUN/DRAIN load the stepped index.
  assign load_idx        = (state_q == S_ARM) ? 8'd0 : idx_step;
  assign duty_load       = duty_of(load_idx, amplitude);

  // Next-state and register loads; every duty change is gated by period_start.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    sample_cnt_d = sample_cnt_q;
    duty_d       = duty_q;
    case (state_q)
      S_IDLE: begin
        idx_d        = '0;
        sample_cnt_d = '0;
        duty_d       = '0;
        if (resume) state_d = S_ARM;
      end
      S_ARM: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (period_start) begin
          state_d      = S_RUN;
          idx_d        = '0;
          sample_cnt_d = '0;
          duty_d       = duty_load;
        end
      end
      S_RUN: begin
        if (period_start) begin
          idx_d        = idx_step;
          sample_cnt_d = sample_cnt_step;
          duty_d       = duty_load;
        end
        if (stop) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (resume) state_d = S_RUN;
        if (period_start) begin
          // A resume on the wrap edge keeps modulating rather than dropping to idle.
          if (cycle_end && !resume) begin
            state_d      = S_IDLE;
            idx_d        = '0;
            sample_cnt_d = '0;
            duty_d       = '0;
          end else begin
            idx_d        = idx_step;
            sample_cnt_d = sample_cnt_step;
            duty_d       = duty_load;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state, sine position and registered duty output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      sample_cnt_q <= '0;
      duty_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sample_cnt_q <= sample_cnt_d;
      duty_q       <= duty_d;
    end
  end

  assign duty_cycle = duty_q;
  assign busy       = (state_q != S_IDLE);
  assign sample_idx = idx_q;

endmodule

// File: tb/tb_pwm_sine_sequencer.sv
// Bench for pwm_sine_sequencer with scaled-down frequencies so a sine cycle is 2048 clocks.
// Expected duties come from a real-valued sine model and hand-derived vector constants.
// Outputs are sampled on the falling clock edge; all waits are cycle-bounded.
module tb_pwm_sine_sequencer;

  localparam int CLK_F       = 2048;
  localparam int PWM_F       = 512;
  localparam int SIN_F       = 1;
  localparam int STEPS       = CLK_F / PWM_F;          // 4
  localparam int SDIV        = 2;                      // 512 / 256
  localparam int SAMPLE_CLKS = STEPS * SDIV;           // 8
  localparam int CYCLE_CLKS  = SAMPLE_CLKS * 256;      // 2048
  localparam int BUDGET      = CYCLE_CLKS + 4 * SAMPLE_CLKS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [6:0]  amplitude = 7'd0;
  logic [31:0] duty_cycle;
  logic        period_start;
  logic        busy;
  logic [7:0]  sample_idx;

  pwm_sine_sequencer #(
    .CLK_FREQUENCY (CLK_F),
    .FREQUENCY     (PWM_F),
    .SINE_FREQUENCY(SIN_F)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .amplitude   (amplitude),
    .duty_cycle  (duty_cycle),
    .period_start(period_start),
    .busy        (busy),
    .sample_idx  (sample_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: 50 + floor(clamp(a)*round(1024*sin(2*pi*idx/256)) / 1024).
  function automatic int model_duty(input int idx, input int amp);
    real r;
    int  s;
    int  a;
    a = (amp > 50) ? 50 : amp;
    r = 1024.0 * $sin(2.0 * 3.14159265358979 * idx / 256.0);
    s = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    return 50 + ((a * s) >>> 10);
  endfunction

  typedef struct { int idx; int duty; } exp_t;
  exp_t sb_q[$];

  typedef struct { int amp; int idx; int duty; } vec_t;
  localparam int NV = 14;
  vec_t vecs[NV];

  // Duty may only move on the edge that follows a period_start cycle.
  logic        mon_en = 1'b0;
  logic [31:0] prev_duty = '0;
  logic        prev_ps = 1'b0;
  int          illegal = 0;
  always @(negedge clk) begin
    if (mon_en && rst_n && !prev_ps && duty_cycle != prev_duty) illegal++;
    prev_duty = duty_cycle;
    prev_ps   = period_start;
  end

  task automatic pulse(input logic s, input logic p);
    start = s;
    stop  = p;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_idx(input int target, input string name);
    int n;
    n = 0;
    while (sample_idx != 8'(target) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (sample_idx != 8'(target)) chk({"timeout ", name}, sample_idx, target);
  endtask

  task automatic wait_run(input string name);
    int n;
    n = 0;
    while (!(busy && duty_cycle == 32'd50) && n < 2 * STEPS + 2) begin
      @(negedge clk);
      n++;
    end
    if (!(busy && duty_cycle == 32'd50)) chk({"timeout ", name}, duty_cycle, 50);
  endtask

  initial begin
    exp_t e;
    int   n;
    int   bad;
    int   cur;
    int   last_idx;
    int   last_duty;

    vecs[0]  = '{50,  32,  85};
    vecs[1]  = '{50,  64,  100};
    vecs[2]  = '{50,  128, 50};
    vecs[3]  = '{50,  192, 0};
    vecs[4]  = '{50,  224, 14};
    vecs[5]  = '{50,  255, 48};
    vecs[6]  = '{70,  64,  100};
    vecs[7]  = '{70,  192, 0};
    vecs[8]  = '{20,  1,   50};
    vecs[9]  = '{20,  64,  70};
    vecs[10] = '{20,  192, 30};
    vecs[11] = '{0,   224, 50};
    vecs[12] = '{127, 64,  100};
    vecs[13] = '{127, 192, 0};

    // Reset state and timebase.
    repeat (3) @(negedge clk);
    chk("reset duty", duty_cycle, 0);
    chk("reset busy", busy, 0);
    chk("reset idx", sample_idx, 0);
    rst_n = 1'b1;
    #1;
    chk("period_start first cycle", period_start, 1);
    for (int c = 1; c <= 3 * STEPS; c++) begin
      @(negedge clk);
      chk($sformatf("period_start cycle %0d", c), period_start, (c % STEPS == 0) ? 1 : 0);
    end
    chk("idle duty", duty_cycle, 0);
    chk("idle busy", busy, 0);
    mon_en = 1'b1;

    // Start with period_cnt at 0: worst-case latency of STEPS+1 edges.
    amplitude = 7'd50;
    pulse(1'b1, 1'b0);
    chk("arm busy", busy, 1);
    chk("arm duty", duty_cycle, 0);
    n = 1;
    while (duty_cycle != 32'd50 && n < 2 * STEPS + 2) begin
      @(negedge clk);
      n++;
    end
    chk("start latency", n, STEPS + 1);
    chk("run first idx", sample_idx, 0);

    // One full sine cycle at full depth: every sample value and hold time.
    for (int k = 1; k <= 256; k++) begin
      e.idx  = k % 256;
      e.duty = model_duty(k % 256, 50);
      sb_q.push_back(e);
    end
    for (int k = 0; k < 256; k++) begin
      cur = sample_idx;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (sample_idx == 8'(cur) && n < 4 * SAMPLE_CLKS);
      e = sb_q.pop_front();
      chk($sformatf("sweep hold %0d", e.idx), n, SAMPLE_CLKS);
      chk($sformatf("sweep idx %0d", e.idx), sample_idx, e.idx);
      chk($sformatf("sweep duty %0d", e.idx), duty_cycle, e.duty);
    end

    // Amplitude vectors: amplitude set one sample ahead, duty checked at the target index.
    for (int r = 0; r < NV; r++) begin
      wait_idx(vecs[r].idx - 1, $sformatf("vec%0d lead-in", r));
      amplitude = 7'(vecs[r].amp);
      e.idx  = vecs[r].idx;
      e.duty = vecs[r].duty;
      sb_q.push_back(e);
      wait_idx(vecs[r].idx, $sformatf("vec%0d idx", r));
      e = sb_q.pop_front();
      chk($sformatf("vec%0d amp %0d idx %0d duty", r, vecs[r].amp, e.idx), duty_cycle, e.duty);
    end

    // Stop at idx 100: drain to the end of the cycle, idle on the wrap edge.
    amplitude = 7'd50;
    wait_idx(100, "stop point");
    pulse(1'b0, 1'b1);
    chk("drain still busy", busy, 1);
    last_idx = sample_idx;
    last_duty = duty_cycle;
    n = 0;
    while (busy && n < BUDGET) begin
      last_idx = sample_idx;
      last_duty = duty_cycle;
      @(negedge clk);
      n++;
    end
    chk("drain busy falls", busy, 0);
    chk("drain length", n + 1, 156 * SAMPLE_CLKS);
    chk("drain last idx", last_idx, 255);
    chk("drain last duty", last_duty, model_duty(255, 50));
    chk("wrap duty", duty_cycle, 0);
    chk("wrap idx", sample_idx, 0);

    // Start during DRAIN resumes RUN with the index continuing.
    pulse(1'b1, 1'b0);
    wait_run("restart1");
    wait_idx(10, "drain-resume 10");
    pulse(1'b0, 1'b1);
    wait_idx(12, "drain-resume 12");
    pulse(1'b1, 1'b0);
    n = 1;
    while (sample_idx == 8'd12 && n < 4 * SAMPLE_CLKS) begin
      @(negedge clk);
      n++;
    end
    chk("resume busy", busy, 1);
    chk("resume interval", n, SAMPLE_CLKS);
    chk("resume idx", sample_idx, 13);
    chk("resume duty", duty_cycle, model_duty(13, 50));
    wait_idx(0, "resume wrap");
    chk("resumed run survives wrap", busy, 1);
    chk("resumed wrap duty", duty_cycle, 50);
    pulse(1'b0, 1'b1);
    n = 0;
    while (busy && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("second drain idle", busy, 0);
    chk("second drain duty", duty_cycle, 0);

    // Start and stop together in IDLE: remain idle.
    pulse(1'b1, 1'b1);
    bad = 0;
    for (int c = 0; c < 2 * STEPS; c++) begin
      if (busy || duty_cycle != 32'd0) bad++;
      @(negedge clk);
    end
    chk("start+stop in idle", bad, 0);

    // Stop while armed: back to IDLE without a duty load.
    n = 0;
    while (!period_start && n < STEPS + 1) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("armed before stop", busy, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop in arm", busy, 0);
    bad = 0;
    for (int c = 0; c < 2 * STEPS + 1; c++) begin
      if (busy || duty_cycle != 32'd0) bad++;
      @(negedge clk);
    end
    chk("stop in arm keeps duty 0", bad, 0);

    // Asynchronous reset between boundaries while running.
    pulse(1'b1, 1'b0);
    wait_run("restart2");
    wait_idx(3, "pre-reset");
    n = 0;
    while (period_start && n < STEPS) begin
      @(negedge clk);
      n++;
    end
    chk("pre-reset duty", duty_cycle, model_duty(3, 50));
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async reset duty", duty_cycle, 0);
    chk("async reset busy", busy, 0);
    chk("async reset idx", sample_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("period_start after release", period_start, 1);
    for (int c = 1; c <= 2 * STEPS; c++) begin
      @(negedge clk);
      chk($sformatf("post-reset period_start %0d", c), period_start, (c % STEPS == 0) ? 1 : 0);
    end
    chk("post-reset busy", busy, 0);

    chk("duty changes only on period boundaries", illegal, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
